// File: rtl/ifid_stage.sv
// rtl/ifid_stage.sv - IF/ID two-entry skid buffer with instruction field split
// Optional stall counter enabled by defining IFID_STATS_EN.
module ifid_stage #(
  parameter int DW   = 32,
  parameter int IMMW = 22
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_instr,
  input  logic [DW-1:0]   in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_instr,
  output logic [DW-1:0]   out_pc,
  output logic [3:0]      out_opcode,
  output logic [5:0]      out_rd,
  output logic [5:0]      out_rs,
  output logic [5:0]      out_rt,
  output logic [IMMW-1:0] out_imm
`ifdef IFID_STATS_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] m_instr, m_pc, s_instr, s_pc;
  logic          in_xfer, out_xfer;
  logic          load_m_in, load_m_s, load_s;

  assign out_valid = (state != EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Flush wins over every transfer; M keeps the oldest entry, S the younger one.
  always_comb begin
    state_nxt = state;
    load_m_in = 1'b0;
    load_m_s  = 1'b0;
    load_s    = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_xfer) begin
          state_nxt = ONE;
          load_m_in = 1'b1;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_m_in = 1'b1;
          end else if (in_xfer) begin
            state_nxt = TWO;
            load_s    = 1'b1;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (out_xfer) begin
          state_nxt = ONE;
          load_m_s  = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b1;
      m_instr  <= '0;
      m_pc     <= '0;
      s_instr  <= '0;
      s_pc     <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != TWO);
      if (load_m_in) begin
        m_instr <= in_instr;
        m_pc    <= in_pc;
      end else if (load_m_s) begin
        m_instr <= s_instr;
        m_pc    <= s_pc;
      end
      if (load_s) begin
        s_instr <= in_instr;
        s_pc    <= in_pc;
      end
    end
  end

  // rs and imm overlap on bits [21:16] by design of the instruction format.
  assign out_instr  = m_instr;
  assign out_pc     = m_pc;
  assign out_opcode = m_instr[31:28];
  assign out_rd     = m_instr[27:22];
  assign out_rs     = m_instr[21:16];
  assign out_rt     = m_instr[15:10];
  assign out_imm    = m_instr[IMMW-1:0];

`ifdef IFID_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ifid_stage.md
Name: ifid_stage

Overview:
- Instruction-fetch to decode pipeline stage: two-entry skid buffer between instruction memory and decode.
- Holds each fetched 32-bit instruction and its PC, and splits the instruction into opcode, rd, rs, rt and the 22-bit immediate field.
- The 22-bit immediate field goes directly to the immediate generator.
- Supports back-pressure from decode (stalls) and branch flushes without losing or duplicating instructions.

Parameters:
- DW, 32, instruction and PC width.
- IMMW, 22, immediate field width (instruction bits [IMMW-1:0]).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; registered output.
- in_instr  input  DW  fetched instruction.
- in_pc  input  DW  PC of the fetched instruction.
- flush  input  1  discard all held instructions (taken branch/jump).
- out_valid  output  1  decode fields are valid.
- out_ready  input  1  decode consumes this cycle.
- out_instr  output  DW  held instruction.
- out_pc  output  DW  held PC.
- out_opcode  output  4  out_instr[31:28].
- out_rd  output  6  out_instr[27:22].
- out_rs  output  6  out_instr[21:16].
- out_rt  output  6  out_instr[15:10].
- out_imm  output  IMMW  out_instr[21:0], raw and unextended.
- stall_cnt  output  16  back-pressure cycle count; present only with IFID_STATS_EN.

Behaviour:
- Reset: Rst_n is sampled at a posedge only, with the Clk-domain reset fixed as synchronous active-low.
  - While Rst_n=0 at a posedge: state becomes EMPTY, out_valid=0, in_ready=1, out_instr=0, out_pc=0, all field outputs 0, stall_cnt=0.
  - A reset asserted mid-operation discards all held entries.
- Storage:
  - Main register M drives the outputs.
  - Skid register S holds an entry only when decode stalled while in_ready was still 1.
- Transfers:
  - Input transfer: in_valid & in_ready at a posedge.
  - Output transfer: out_valid & out_ready at a posedge.
- States:
  - EMPTY: M and S empty.
  - ONE: M full, S empty.
  - TWO: M and S full.
- Transitions (flush=0):
  - EMPTY + input -> ONE. M <= input; out_valid rises the next cycle, so latency is 1 cycle.
  - ONE + input + output -> ONE. M <= input.
  - ONE + input, no output -> TWO. S <= input.
  - ONE + output, no input -> EMPTY.
  - TWO + output -> ONE. M <= S. No input is possible in TWO.
  - No transfer in any state -> hold; outputs stable.
- in_ready = (state != TWO), registered.
- out_valid = (state != EMPTY).
- FIFO order is strict: M is always older than S.
- Field outputs are pure slices of M. The rs/imm overlap (bits [21:16]) is intentional.
- Flush has priority over everything else:
  - flush=1 at a posedge -> EMPTY, out_valid=0, in_ready=1.
  - An instruction offered in the same cycle is dropped, even if in_ready was 1.
  - An output transfer in the flush cycle still counts as consumed by decode.
- Data in M and S is unchanged while held. Outputs do not glitch between transfers.
- No combinational path exists from any input to in_ready or out_valid.

Optional Feature:
- Macro: IFID_STATS_EN.
- Defined:
  - stall_cnt increments by 1 each posedge where out_valid=1 and out_ready=0.
  - stall_cnt saturates at 16'hFFFF.
  - Cleared by reset only; flush does not clear it.
- Undefined:
  - stall_cnt port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then single instr: Rst_n=0 for 2 cycles, then in_instr=32'h1A5FFFFF, in_pc=0x10, out_ready=1.
  - Next cycle: out_valid=1, out_opcode=4'h1, out_rd=6'h29, out_rs=6'h1F, out_rt=6'h3F, out_imm=22'h1FFFFF, out_pc=0x10.
- Back-pressure: stream instrs A, B, C with out_ready=0.
  - A lands in M, B in S, in_ready=0 the following cycle, C is held by fetch.
  - Release out_ready: outputs are A, B, C in order, one per cycle, none lost or duplicated.
- Flush: in state TWO, assert flush with in_valid=1 carrying D.
  - Next cycle: out_valid=0, in_ready=1, D is never output.
- Simultaneous flow: out_ready=1 and in_valid=1 every cycle for 100 instrs.
  - Stays in ONE, in_ready constantly 1, output sequence equals input sequence delayed by 1 cycle.
- Reset mid-operation: in TWO, Rst_n=0 for one posedge.
  - out_valid=0, in_ready=1, outputs zero, stall_cnt=0.
- IFID_STATS_EN: hold out_ready=0 with out_valid=1 for 70000 cycles.
  - stall_cnt=16'hFFFF and holds; a flush leaves it unchanged.
